// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - write strobe and read valid/ready bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
   parameter int N = 8
);
   logic         wr_valid_i;
   logic [N-1:0] wr_data_i;
   logic         wr_perr_i;
   logic         rd_ready_i;
   logic         rd_valid_o;
   logic [N-1:0] rd_data_o;
   logic         rd_perr_o;

   modport master (
      output wr_valid_i, wr_data_i, wr_perr_i, rd_ready_i,
      input  rd_valid_o, rd_data_o, rd_perr_o
   );

   modport slave (
      input  wr_valid_i, wr_data_i, wr_perr_i, rd_ready_i,
      output rd_valid_o, rd_data_o, rd_perr_o
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular receive FIFO behind the UART with sticky overrun flag
// Optional per-entry parity flag storage enabled by UART_RX_FIFO_PERR_EN.
module uart_rx_fifo #(
   parameter int N        = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                   sysclk,
   input  logic                   reset_n,
   uart_rx_fifo_if.slave          bus,
   input  logic                   clr_overrun_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   almost_full_o,
   output logic                   overrun_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_valid;
   logic          r_empty;
   logic          r_full;
   logic          r_af;
   logic          r_ovr;
   logic [N-1:0]  r_mem [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [CW-1:0] w_count_nxt;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_pop       = r_valid & bus.rd_ready_i;
   assign w_push      = bus.wr_valid_i & (~r_full | w_pop);
   assign w_drop      = bus.wr_valid_i & r_full & ~w_pop;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_af     <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
         if (w_drop)             r_ovr <= 1'b1;
         else if (clr_overrun_i) r_ovr <= 1'b0;
      end
   end

   // Storage is deliberately not reset; only the pointers define what is valid.
   always_ff @(posedge sysclk) begin
      if (reset_n && w_push) r_mem[r_wr_ptr] <= bus.wr_data_i;
   end

`ifdef UART_RX_FIFO_PERR_EN
   logic r_perr_mem [DEPTH];

   always_ff @(posedge sysclk) begin
      if (reset_n && w_push) r_perr_mem[r_wr_ptr] <= bus.wr_perr_i;
   end

   assign bus.rd_perr_o = r_perr_mem[r_rd_ptr];
`else
   logic w_unused_perr;

   assign w_unused_perr = bus.wr_perr_i;
   assign bus.rd_perr_o = 1'b0;
`endif

   assign bus.rd_valid_o = r_valid;
   assign bus.rd_data_o  = r_mem[r_rd_ptr];
   assign count_o        = r_count;
   assign empty_o        = r_empty;
   assign full_o         = r_full;
   assign almost_full_o  = r_af;
   assign overrun_o      = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
   localparam int N        = 8;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;

   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clr_overrun_i = 1'b0;
   logic [4:0] count_o;
   logic       empty_o, full_o, almost_full_o, overrun_o;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] exp_q [$];
   int         m_cnt = 0;
   logic       m_ovr = 1'b0;

   uart_rx_fifo_if #(.N(N)) bus ();

   uart_rx_fifo #(.N(N), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .sysclk        (sysclk),
      .reset_n       (reset_n),
      .bus           (bus),
      .clr_overrun_i (clr_overrun_i),
      .count_o       (count_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .overrun_o     (overrun_o)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic perr_eff(input logic p);
`ifdef UART_RX_FIFO_PERR_EN
      return p;
`else
      return 1'b0;
`endif
   endfunction

   // One clock of stimulus; head is sampled before the edge, model updated, outputs settle #1 after.
   task automatic drive(input logic wv, input logic [7:0] wd, input logic wp, input logic rr,
                        input logic clr, output logic exp_pop, output logic [9:0] obs);
      logic push_m;
      bus.wr_valid_i = wv;
      bus.wr_data_i  = wd;
      bus.wr_perr_i  = wp;
      bus.rd_ready_i = rr;
      clr_overrun_i  = clr;
      obs     = {bus.rd_valid_o, bus.rd_perr_o, bus.rd_data_o};
      exp_pop = (m_cnt > 0) && rr;
      push_m  = wv && ((m_cnt < DEPTH) || exp_pop);
      if (push_m) exp_q.push_back({perr_eff(wp), wd});
      if (wv && !push_m) m_ovr = 1'b1;
      else if (clr)      m_ovr = 1'b0;
      m_cnt = m_cnt + int'(push_m) - int'(exp_pop);
      @(posedge sysclk);
      #1;
      bus.wr_valid_i = 1'b0;
      bus.rd_ready_i = 1'b0;
      clr_overrun_i  = 1'b0;
   endtask

   task automatic apply_reset();
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'hFF;
      bus.wr_perr_i  = 1'b1;
      bus.rd_ready_i = 1'b1;
      reset_n = 1'b0;
      @(posedge sysclk);
      @(posedge sysclk);
      #1;
      reset_n = 1'b1;
      bus.wr_valid_i = 1'b0;
      bus.rd_ready_i = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      m_ovr = 1'b0;
   endtask

   task automatic test_reset();
      logic ep;
      logic [9:0] o;
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (bus.rd_valid_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
             almost_full_o !== 1'b0 || overrun_o !== 1'b0 || count_o !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_idle[%0d]: got valid=%b empty=%b full=%b af=%b ovr=%b count=%0d, want 0 1 0 0 0 0",
                     i, bus.rd_valid_o, empty_o, full_o, almost_full_o, overrun_o, count_o);
         end
         if (i < 10) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
      end
   endtask

   task automatic test_single();
      logic ep;
      logic [9:0] o;
      logic [8:0] e;
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, ep, o);
      n_cmp++;
      if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h55 || count_o !== 5'd1) begin
         n_bad++;
         $display("FAIL single_write: got valid=%b data=%h count=%0d, want 1 55 1",
                  bus.rd_valid_o, bus.rd_data_o, count_o);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ep, o);
         n_cmp++;
         if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h55) begin
            n_bad++;
            $display("FAIL single_hold: got valid=%b data=%h, want 1 55", bus.rd_valid_o, bus.rd_data_o);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
      if (ep) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (o[9] !== 1'b1 || o[8:0] !== e) begin
            n_bad++;
            $display("FAIL single_pop: got valid=%b perr/data=%h, want 1 %h", o[9], o[8:0], e);
         end
      end
      n_cmp++;
      if (empty_o !== 1'b1 || bus.rd_valid_o !== 1'b0 || count_o !== 5'd0) begin
         n_bad++;
         $display("FAIL single_empty: got empty=%b valid=%b count=%0d, want 1 0 0",
                  empty_o, bus.rd_valid_o, count_o);
      end
   endtask

   task automatic test_fill_overrun();
      logic ep;
      logic [9:0] o;
      logic [8:0] e;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, ep, o);
         n_cmp++;
         if (almost_full_o !== (m_cnt >= AF_LEVEL) || full_o !== (m_cnt == DEPTH) ||
             count_o !== 5'(m_cnt)) begin
            n_bad++;
            $display("FAIL fill_flags[%0d]: got af=%b full=%b count=%0d, want %b %b %0d", i,
                     almost_full_o, full_o, count_o, m_cnt >= AF_LEVEL, m_cnt == DEPTH, m_cnt);
         end
      end
      drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, ep, o);
      n_cmp++;
      if (overrun_o !== 1'b1 || count_o !== 5'd16 || full_o !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_drop: got ovr=%b count=%0d full=%b, want 1 16 1", overrun_o, count_o, full_o);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
         if (ep) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (o[9] !== 1'b1 || o[8:0] !== e) begin
               n_bad++;
               $display("FAIL fill_drain[%0d]: got valid=%b perr/data=%h, want 1 %h", i, o[9], o[8:0], e);
            end
         end
      end
      n_cmp++;
      if (empty_o !== 1'b1 || overrun_o !== 1'b1) begin
         n_bad++;
         $display("FAIL drained_sticky: got empty=%b ovr=%b, want 1 1", empty_o, overrun_o);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ep, o);
      n_cmp++;
      if (overrun_o !== m_ovr) begin
         n_bad++;
         $display("FAIL overrun_clear: got %b, want %b", overrun_o, m_ovr);
      end
   endtask

   task automatic test_full_push_pop();
      logic ep;
      logic [9:0] o;
      logic [8:0] e;
      logic [7:0] last;
      last = 8'h00;
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, ep, o);
      drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, ep, o);
      if (ep) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (o[9] !== 1'b1 || o[8:0] !== e) begin
            n_bad++;
            $display("FAIL fullpp_pop: got valid=%b perr/data=%h, want 1 %h", o[9], o[8:0], e);
         end
      end
      n_cmp++;
      if (overrun_o !== 1'b0 || count_o !== 5'd16) begin
         n_bad++;
         $display("FAIL fullpp_state: got ovr=%b count=%0d, want 0 16", overrun_o, count_o);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
         if (ep) begin
            e = exp_q.pop_front();
            last = o[7:0];
            n_cmp++;
            if (o[9] !== 1'b1 || o[8:0] !== e) begin
               n_bad++;
               $display("FAIL fullpp_drain[%0d]: got valid=%b perr/data=%h, want 1 %h", i, o[9], o[8:0], e);
            end
         end
      end
      n_cmp++;
      if (last !== 8'h77 || empty_o !== 1'b1) begin
         n_bad++;
         $display("FAIL fullpp_last: got last=%h empty=%b, want 77 1", last, empty_o);
      end
   endtask

   task automatic test_wrap();
      logic ep;
      logic [9:0] o;
      logic [8:0] e;
      int wr_n;
      wr_n = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'(wr_n), 1'b0, 1'b0, 1'b0, ep, o);
         wr_n++;
      end
      for (int c = 0; c < 80 + 12; c++) begin
         if (c < 80 && c % 2 == 0) begin
            drive(1'b1, 8'(wr_n), 1'b0, 1'b0, 1'b0, ep, o);
            wr_n++;
         end else begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
         end
         if (ep) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (o[9] !== 1'b1 || o[8:0] !== e) begin
               n_bad++;
               $display("FAIL wrap_seq[%0d]: got valid=%b perr/data=%h, want 1 %h", c, o[9], o[8:0], e);
            end
         end
      end
      n_cmp++;
      if (overrun_o !== 1'b0 || empty_o !== 1'b1 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL wrap_end: got ovr=%b empty=%b left=%0d, want 0 1 0", overrun_o, empty_o, exp_q.size());
      end
   endtask

   task automatic test_perr();
      logic ep;
      logic [9:0] o;
      logic [8:0] e;
      drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, ep, o);
      drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, ep, o);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ep, o);
         if (ep) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (o[9] !== 1'b1 || o[8:0] !== e) begin
               n_bad++;
               $display("FAIL perr_pop[%0d]: got valid=%b perr=%b data=%h, want 1 %b %h",
                        i, o[9], o[8], o[7:0], e[8], e[7:0]);
            end
         end
      end
      n_cmp++;
      if (bus.rd_perr_o !== 1'b0 && bus.rd_valid_o === 1'b1) begin
         n_bad++;
         $display("FAIL perr_empty: got valid=%b perr=%b, want 0 x", bus.rd_valid_o, bus.rd_perr_o);
      end
   endtask

   task automatic test_clr_overrun();
      logic ep;
      logic [9:0] o;
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0, ep, o);
      drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, ep, o);
      n_cmp++;
      if (overrun_o !== 1'b1 || count_o !== 5'd16) begin
         n_bad++;
         $display("FAIL clr_vs_set: got ovr=%b count=%0d, want 1 16", overrun_o, count_o);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ep, o);
      n_cmp++;
      if (overrun_o !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_alone: got ovr=%b, want 0", overrun_o);
      end
      apply_reset();
      n_cmp++;
      if (count_o !== 5'd0 || bus.rd_valid_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: got count=%0d valid=%b empty=%b full=%b, want 0 0 1 0",
                  count_o, bus.rd_valid_o, empty_o, full_o);
      end
   endtask

   initial begin
      bus.wr_valid_i = 1'b0;
      bus.wr_data_i  = 8'h00;
      bus.wr_perr_i  = 1'b0;
      bus.rd_ready_i = 1'b0;
      test_reset();
      test_single();
      test_fill_overrun();
      test_full_push_pop();
      test_wrap();
      test_perr();
      test_clr_overrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
